dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Sequencing controller and arbiter for the single-port data memory behind the CPU's MEM stage. It shares the memory between the pipeline's MEM-stage port and a debug/loader port. It drives a fixed-latency memory through an issue/wait/respond FSM and holds the pipeline via a stall output until the CPU access completes. It sits between EX_MEM/MEM_WB and the data memory array.

Parameters:
ADDR_W, 32, address width of both requester ports and the memory port
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en_o cycle to valid mem_rdata_i; legal range 1..15
STARVE_MAX, 4, consecutive CPU grants allowed while a debug request waits; legal range 1..15

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
cpu_req_i  in  1  MEM-stage access request; held until cpu_done_o
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  ADDR_W  byte address
cpu_wdata_i  in  DATA_W  write data
cpu_stall_o  out  1  pipeline hold
cpu_done_o  out  1  one-cycle completion pulse
cpu_rdata_o  out  DATA_W  last CPU read data
dbg_req_i  in  1  debug request; held until dbg_done_o
dbg_we_i  in  1  1=write
dbg_addr_i  in  ADDR_W  byte address
dbg_wdata_i  in  DATA_W  write data
dbg_gnt_o  out  1  debug port owns the memory
dbg_done_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  DATA_W  last debug read data
mem_en_o  out  1  memory access strobe, one cycle per transaction
mem_we_o  out  1  write qualifier, valid with mem_en_o
mem_addr_o  out  ADDR_W  address, valid with mem_en_o
mem_wdata_o  out  DATA_W  write data, valid with mem_en_o
mem_rdata_i  in  DATA_W  read data, valid MEM_LAT cycles after mem_en_o

Behaviour:
- Reset (rst_i=0, asynchronous):
  - Set state=IDLE, owner=CPU, wait counter=0, starve counter=0.
  - Drive every output register to 0, including both rdata outputs.
  - cpu_stall_o is combinational and follows cpu_req_i while in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, arbitrate in that cycle.
  - Latch the winner's owner, we, addr and wdata.
  - Go to ISSUE; otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_en_o=1, with mem_we_o, mem_addr_o and mem_wdata_o taken from the latched fields.
  - Load wait counter=MEM_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==1: for a read, capture mem_rdata_i into the owner's rdata register at that clock edge; then go to RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP (1 cycle):
  - Owner's done_o=1; go to IDLE.
  - A write leaves both rdata registers unchanged.
- Latency: request first seen in IDLE at cycle t gives done at t+MEM_LAT+2. The next arbitration is at t+MEM_LAT+3 at the earliest.
- Memory-port outputs are 0 outside ISSUE, except that mem_addr_o, mem_wdata_o and mem_we_o may hold their last values; the bench checks them only when mem_en_o=1.
- cpu_stall_o = cpu_req_i AND NOT (state==RESP AND owner==CPU).
  - Stall is therefore high from the request cycle through the cycle before done, including the whole time debug owns the memory.
- dbg_gnt_o = 1 in ISSUE, WAIT and RESP when owner==DBG.
- Arbitration in IDLE:
  - CPU has fixed priority.
  - Exception: debug wins when dbg_req_i=1 and starve counter==STARVE_MAX.
- Starve counter:
  - +1 on each CPU grant made while dbg_req_i=1, saturating at STARVE_MAX.
  - Cleared on a debug grant, and on any CPU grant made while dbg_req_i=0.
- Request deassertion:
  - Dropping a request after it has been latched does not abort the transaction; done still pulses.
  - The latched fields are immune to input changes after IDLE.
- Simultaneous requests with counter below STARVE_MAX: the CPU is served; the debug request stays pending, with no lost state.
- Reset mid-transaction:
  - Immediate return to IDLE with no done pulse.
  - A memory write already strobed is not retracted.
  - A request still held after reset release is re-arbitrated normally.
- No address alignment or range checking; addresses pass through unchanged.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner enum {OWN_CPU, OWN_DBG}
  - the counter width constant, 4 bits
- The arbitration decision plus starve counter form a natural sub-module, dmem_arb_pick, which is combinational except for the counter.
- The FSM and datapath latches stay in the top module.

Test Plan:
1. MEM_LAT=2; CPU read of 0x10 at t, memory returns 0xDEADBEEF -> mem_en_o=1, mem_we_o=0, mem_addr_o=0x10 at t+1; cpu_done_o=1 and cpu_rdata_o=0xDEADBEEF at t+4; cpu_stall_o=1 at t..t+3 and 0 at t+4.
2. CPU read and debug read both raised at t, CPU drops its request after done -> CPU done at t+4; dbg_gnt_o rises at t+6; dbg_done_o at t+9; cpu_stall_o stays 0.
3. STARVE_MAX=4; CPU requests continuously and debug is held -> 4 CPU transactions, 5th grant to debug, 6th back to CPU; cpu_stall_o=1 throughout debug ownership.
4. Debug write of 0x12345678 to 0x20 -> exactly one mem_en_o cycle with mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x12345678; one dbg_done_o pulse; dbg_rdata_o unchanged.
5. rst_i pulled low during WAIT of a CPU read -> outputs 0 within the same cycle, no cpu_done_o; after release, the held request is re-issued and done arrives MEM_LAT+2 cycles later.
6. MEM_LAT=1 build; CPU read at t -> done at t+3, with data sampled at the clock edge ending t+2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its pick logic.
package dmem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Arbitration between the MEM-stage and debug ports: CPU has fixed priority,
// debug is forced through once it has waited out STARVE_MAX CPU grants.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   dbg_req,
  output owner_t pick
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve;

  always_comb begin
    pick = OWN_CPU;
    if (dbg_req && (!cpu_req || starve == STARVE_LIM)) pick = OWN_DBG;
  end

  // Counts CPU grants that passed over a waiting debug request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve <= '0;
    end else if (arb_en) begin
      if (pick == OWN_DBG || !dbg_req) starve <= '0;
      else if (starve != STARVE_LIM)   starve <= starve + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory sequencer: arbitrates CPU/debug ports, drives a fixed-latency
// memory through IDLE/ISSUE/WAIT/RESP and stalls the pipeline until done.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic              cpu_done_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  import dmem_arb_pkg::*;

  state_t           state;
  owner_t           owner;
  owner_t           pick;
  logic             lat_we;
  logic [CNT_W-1:0] wait_cnt;
  logic             arb_en;

  assign arb_en      = (state == IDLE) && (cpu_req_i || dbg_req_i);
  assign cpu_stall_o = cpu_req_i && !(state == RESP && owner == OWN_CPU);

  dmem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .arb_en (arb_en),
    .cpu_req(cpu_req_i),
    .dbg_req(dbg_req_i),
    .pick   (pick)
  );

  // mem_addr_o/mem_wdata_o double as the latched request fields; outputs are
  // registered one state early so they line up with ISSUE/RESP exactly.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      lat_we      <= 1'b0;
      wait_cnt    <= '0;
      cpu_done_o  <= 1'b0;
      cpu_rdata_o <= '0;
      dbg_gnt_o   <= 1'b0;
      dbg_done_o  <= 1'b0;
      dbg_rdata_o <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      cpu_done_o <= 1'b0;
      dbg_done_o <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_en) begin
            owner    <= pick;
            state    <= ISSUE;
            mem_en_o <= 1'b1;
            if (pick == OWN_DBG) begin
              lat_we      <= dbg_we_i;
              mem_we_o    <= dbg_we_i;
              mem_addr_o  <= dbg_addr_i;
              mem_wdata_o <= dbg_wdata_i;
              dbg_gnt_o   <= 1'b1;
            end else begin
              lat_we      <= cpu_we_i;
              mem_we_o    <= cpu_we_i;
              mem_addr_o  <= cpu_addr_i;
              mem_wdata_o <= cpu_wdata_i;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_W'(MEM_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            state <= RESP;
            if (owner == OWN_DBG) begin
              dbg_done_o <= 1'b1;
              if (!lat_we) dbg_rdata_o <= mem_rdata_i;
            end else begin
              cpu_done_o <= 1'b1;
              if (!lat_we) cpu_rdata_o <= mem_rdata_i;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          dbg_gnt_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-schedule model,
// plus directed reset and MEM_LAT=1 / STARVE_MAX=1 sequences.
module tb_dmem_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, dbg_addr_i, dbg_wdata_i, mem_rdata_i;
  logic        cpu_stall_o, cpu_done_o, dbg_gnt_o, dbg_done_o, mem_en_o, mem_we_o;
  logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_addr_o, mem_wdata_o;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_stall_o(cpu_stall_o), .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_done_o(dbg_done_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  logic        l1_cpu_req_i, l1_cpu_we_i, l1_dbg_req_i, l1_dbg_we_i;
  logic [31:0] l1_cpu_addr_i, l1_cpu_wdata_i, l1_dbg_addr_i, l1_dbg_wdata_i, l1_mem_rdata_i;
  logic        l1_cpu_stall_o, l1_cpu_done_o, l1_dbg_gnt_o, l1_dbg_done_o, l1_mem_en_o, l1_mem_we_o;
  logic [31:0] l1_cpu_rdata_o, l1_dbg_rdata_o, l1_mem_addr_o, l1_mem_wdata_o;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(1)) u_dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(l1_cpu_req_i), .cpu_we_i(l1_cpu_we_i), .cpu_addr_i(l1_cpu_addr_i), .cpu_wdata_i(l1_cpu_wdata_i),
    .cpu_stall_o(l1_cpu_stall_o), .cpu_done_o(l1_cpu_done_o), .cpu_rdata_o(l1_cpu_rdata_o),
    .dbg_req_i(l1_dbg_req_i), .dbg_we_i(l1_dbg_we_i), .dbg_addr_i(l1_dbg_addr_i), .dbg_wdata_i(l1_dbg_wdata_i),
    .dbg_gnt_o(l1_dbg_gnt_o), .dbg_done_o(l1_dbg_done_o), .dbg_rdata_o(l1_dbg_rdata_o),
    .mem_en_o(l1_mem_en_o), .mem_we_o(l1_mem_we_o), .mem_addr_o(l1_mem_addr_o), .mem_wdata_o(l1_mem_wdata_o),
    .mem_rdata_i(l1_mem_rdata_i)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Memory: valid read data only in the single cycle MEM_LAT after the strobe.
  logic [31:0] mem_model [logic [31:0]];
  int          pend_c = -100;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  always @(negedge clk_i) begin
    mem_rdata_i = (cyc == pend_c + L) ? mem_peek(pend_addr) : $urandom;
    if (mem_en_o) begin
      pend_c    = cyc;
      pend_addr = mem_addr_o;
      if (mem_we_o) mem_model[mem_addr_o] = mem_wdata_o;
    end
  end

  int          l1_en_c = -100;
  logic [31:0] l1_en_addr;
  always @(negedge clk_i) begin
    l1_mem_rdata_i = (cyc == l1_en_c + 1) ? {16'hA5A5, l1_en_addr[15:0]} : $urandom;
    if (l1_mem_en_o) begin
      l1_en_c    = cyc;
      l1_en_addr = l1_mem_addr_o;
    end
  end

  // Requesters (index 0 = CPU, 1 = debug) and the transaction-level model.
  logic        rq [2];
  logic        rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rwd [2];
  bit          infl [2];
  logic [31:0] exp_rd [2];
  bit          gen_en;
  bit          active;
  int          own, t_en, t_done, starve, c;
  logic        t_we;
  logic [31:0] t_addr, t_wd;

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic drive_reqs();
    for (int p = 0; p < 2; p++) begin
      if (infl[p]) begin
        if ($urandom_range(0, 9) == 0) rq[p] = 1'b0;
        rwe[p]   = 1'($urandom_range(0, 1));
        raddr[p] = $urandom;
        rwd[p]   = $urandom;
      end else if (!rq[p] && gen_en && $urandom_range(0, 3) < ((p == 0) ? 3 : 1)) begin
        rq[p]    = 1'b1;
        rwe[p]   = 1'($urandom_range(0, 1));
        raddr[p] = rnd_addr();
        rwd[p]   = $urandom;
      end
    end
    cpu_req_i = rq[0]; cpu_we_i = rwe[0]; cpu_addr_i = raddr[0]; cpu_wdata_i = rwd[0];
    dbg_req_i = rq[1]; dbg_we_i = rwe[1]; dbg_addr_i = raddr[1]; dbg_wdata_i = rwd[1];
  endtask

  task automatic model_arb();
    if (rst_i && !active && (rq[0] || rq[1])) begin
      own = (rq[1] && (!rq[0] || starve == SMAX)) ? 1 : 0;
      if (own == 1 || !rq[1]) starve = 0;
      else if (starve < SMAX) starve++;
      active   = 1'b1;
      t_en     = c + 1;
      t_done   = c + L + 2;
      t_we     = rwe[own];
      t_addr   = raddr[own];
      t_wd     = rwd[own];
      infl[own] = 1'b1;
    end
  endtask

  task automatic check_cycle();
    bit en_e, done_e;
    en_e   = active && c == t_en;
    done_e = active && c == t_done;
    chk("mem_en", mem_en_o, en_e);
    if (en_e) begin
      chk("mem_we", mem_we_o, t_we);
      chk("mem_addr", mem_addr_o, t_addr);
      if (t_we) chk("mem_wdata", mem_wdata_o, t_wd);
    end
    chk("dbg_gnt", dbg_gnt_o, active && own == 1 && c >= t_en);
    chk("cpu_done", cpu_done_o, done_e && own == 0);
    chk("dbg_done", dbg_done_o, done_e && own == 1);
    chk("cpu_stall", cpu_stall_o, rq[0] && !(done_e && own == 0));
    if (done_e && !t_we) exp_rd[own] = mem_peek(t_addr);
    chk("cpu_rdata", cpu_rdata_o, exp_rd[0]);
    chk("dbg_rdata", dbg_rdata_o, exp_rd[1]);
    if (done_e) begin
      active    = 1'b0;
      infl[own] = 1'b0;
      rq[own]   = 1'b0;
    end
  endtask

  task automatic cycle_body();
    drive_reqs();
    model_arb();
    #5;
    check_cycle();
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    c = cyc;
    cycle_body();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, mem_en_o, 1'b0);
    chk({tag, "_cpu_done"}, cpu_done_o, 1'b0);
    chk({tag, "_dbg_done"}, dbg_done_o, 1'b0);
    chk({tag, "_dbg_gnt"}, dbg_gnt_o, 1'b0);
    chk({tag, "_cpu_rdata"}, cpu_rdata_o, 32'h0);
    chk({tag, "_dbg_rdata"}, dbg_rdata_o, 32'h0);
    chk({tag, "_cpu_stall"}, cpu_stall_o, cpu_req_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0; infl[p] = 1'b0; exp_rd[p] = '0;
    end
    gen_en = 1'b0; active = 1'b0; starve = 0; own = 0; t_en = 0; t_done = 0; c = 0;
    t_we = 1'b0; t_addr = '0; t_wd = '0;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0;
    l1_cpu_req_i = 0; l1_cpu_we_i = 0; l1_cpu_addr_i = '0; l1_cpu_wdata_i = '0;
    l1_dbg_req_i = 0; l1_dbg_we_i = 0; l1_dbg_addr_i = '0; l1_dbg_wdata_i = '0;

    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outputs("por");
    cpu_req_i = 1'b1;
    #1;
    chk("por_stall_follows_req", cpu_stall_o, 1'b1);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;

    gen_en = 1'b1;
    repeat (3000) step();
    gen_en = 1'b0;
    for (int i = 0; i < 40 && (active || rq[0] || rq[1]); i++) step();
    chk("drain_idle", active || rq[0] || rq[1], 1'b0);

    // Reset during WAIT of a CPU read; the held request must be re-issued.
    @(posedge clk_i);
    #1;
    c = cyc;
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h10; rwd[0] = 32'h0;
    cycle_body();
    step();
    step();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    active = 1'b0; infl[0] = 1'b0; infl[1] = 1'b0; starve = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    chk_reset_outputs("rst_wait");
    @(posedge clk_i);
    #1;
    chk_reset_outputs("rst_hold");
    rst_i = 1'b1;
    c = cyc;
    cycle_body();
    for (int i = 0; i < L + 2; i++) step();
    chk("rst_reissue_done_seen", rq[0], 1'b0);

    // MEM_LAT=1, STARVE_MAX=1: CPU, debug, CPU with both requests held.
    @(posedge clk_i);
    #1;
    l1_cpu_req_i = 1'b1; l1_cpu_we_i = 1'b0; l1_cpu_addr_i = 32'h44;
    l1_dbg_req_i = 1'b1; l1_dbg_we_i = 1'b0; l1_dbg_addr_i = 32'h88;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) begin
        @(posedge clk_i);
        #1;
      end
      if (k == 8)  l1_dbg_req_i = 1'b0;
      if (k == 12) l1_cpu_req_i = 1'b0;
      #5;
      chk("l1_mem_en", l1_mem_en_o, k == 1 || k == 5 || k == 9);
      if (l1_mem_en_o) chk("l1_mem_addr", l1_mem_addr_o, (k == 5) ? 32'h88 : 32'h44);
      chk("l1_cpu_done", l1_cpu_done_o, k == 3 || k == 11);
      chk("l1_dbg_done", l1_dbg_done_o, k == 7);
      chk("l1_dbg_gnt", l1_dbg_gnt_o, k >= 5 && k <= 7);
      chk("l1_cpu_stall", l1_cpu_stall_o, k != 3 && k != 11 && k < 12);
      if (k == 3 || k == 11) chk("l1_cpu_rdata", l1_cpu_rdata_o, 32'hA5A5_0044);
      if (k == 7) chk("l1_dbg_rdata", l1_dbg_rdata_o, 32'hA5A5_0088);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
